instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the datapath's instruction decoder. Accepts symbolic instruction requests over a valid/ready handshake and encodes each into a 32-bit MIPS word for the supported subset: add, sub, and, or, slt, addi, lw, sw, beq.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory, with backpressure on the memory side.
- Used by testbenches and boot logic to load programs before the single-cycle core runs.

Parameters:
- ADDR_WIDTH, 8: instruction-memory word-address width.
- FIFO_DEPTH, 4: encoded-word buffer entries; power of two, >= 2.
- BASE_ADDR, 0: first word address written after reset or restart.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  4  0=add 1=sub 2=and 3=or 4=slt 5=addi 6=lw 7=sw 8=beq; 9-15 are illegal.
- req_rs  in  5  rs field.
- req_rt  in  5  rt field; this is the destination for addi and lw.
- req_rd  in  5  rd field; used by R-type only.
- req_imm  in  16  immediate; used by I-type only.
- req_last  in  1  marks the final request of the program.
- restart  in  1  leave DONE and begin a new load.
- imem_we  out  1  write request to instruction memory.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wdata  out  32  encoded instruction.
- words_written  out  ADDR_WIDTH+1  count of completed writes since load start.
- err  out  1  sticky: an illegal op was seen.
- done  out  1  high while in DONE.

Behaviour:
- Reset values:
  - state=LOAD; FIFO empty; imem_addr=BASE_ADDR; words_written=0; err=0; done=0; imem_we=0.
  - req_ready=1 in the first cycle after reset.
- Encoding is combinational at the point a request is accepted (accept = req_valid && req_ready):
  - R-type: word = {6'h00, rs, rt, rd, 5'b0, funct}. funct is add=0x20, sub=0x22, and=0x24, or=0x25, slt=0x2A.
  - I-type: word = {opcode, rs, rt, imm}. opcode is addi=0x08, lw=0x23, sw=0x2B, beq=0x04.
  - Fields are used bit-exact with no sign manipulation. Unused request fields are ignored.
- Legal accept: pushes the word into the FIFO at the next edge. Latency is accept at cycle N, imem_we=1 at N+1 at the earliest.
- Illegal accept: the request is consumed and nothing is pushed. err is set at the next edge and stays set until rst.
- req_ready = (state==LOAD) && !fifo_full.
  - No push when full, even if a pop occurs in the same cycle.
- Memory side:
  - imem_we = !fifo_empty. imem_wdata = FIFO head; imem_addr = current address register.
  - A write completes when imem_we && imem_ready. On completion: pop the FIFO, imem_addr += 1, words_written += 1.
  - While imem_ready=0, imem_we, imem_addr and imem_wdata are held stable.
- imem_addr wraps from 2^ADDR_WIDTH-1 to 0. words_written does not wrap; it saturates at its maximum.
- A simultaneous push and pop is allowed when the FIFO is not full; occupancy is unchanged.
- State machine:
  - LOAD: accept requests. An accept with req_last=1 moves to DRAIN, whether the op is legal or illegal.
  - DRAIN: req_ready=0. Moves to DONE in the cycle after the FIFO becomes empty, i.e. after the last completed write.
  - DONE: done=1, req_ready=0, imem_we=0.
    - restart=1 sets imem_addr=BASE_ADDR, words_written=0 and moves to LOAD. err is not cleared.
  - restart is ignored outside DONE.
- Reset mid-operation flushes the FIFO, drops any pending words and clears all state. There is no partial write: imem_we is 0 in the cycle after rst.

Test Plan:
- Single add: add rs=1 rt=2 rd=3, req_last=1, imem_ready=1 -> one write of 0x00221820 at addr 0 one cycle after accept; done=1 two cycles later; words_written=1.
- Mixed program: addi(rs=0, rt=5, imm=7), lw(rs=29, rt=8, imm=4), sw(rs=10, rt=9, imm=8), beq(rs=1, rt=2, imm=0xFFFD), slt(rs=5, rt=6, rd=4) -> words 0x20050007, 0x8FA80004, 0xAD490008, 0x1022FFFD, 0x00A6202A at addrs 0-4, in order.
- Backpressure: imem_ready=0 while 6 requests are offered -> exactly FIFO_DEPTH=4 accepted, then req_ready=0 and imem_we/addr/wdata stable. Raise imem_ready -> remaining requests accepted and all 6 written in order.
- Illegal op: op=12 between two adds -> err=1 from the next cycle; only 2 writes, at addrs 0 and 1; err persists through restart.
- Wrap and restart: ADDR_WIDTH=2, 5 requests -> addrs 0,1,2,3,0 and words_written=5. Then restart in DONE -> next write at BASE_ADDR with words_written counting from 0.
- Reset mid-load: rst asserted with 3 words queued and imem_ready=0 -> next cycle imem_we=0, imem_addr=0, req_ready=1, err=0, and no queued word is ever written.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory bundle for the program loader.
// slave is the loader side, master is the program source / memory side.
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [4:0]            req_rs;
  logic [4:0]            req_rt;
  logic [4:0]            req_rd;
  logic [15:0]           req_imm;
  logic                  req_last;
  logic                  imem_we;
  logic                  imem_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt,
    input  req_rd, req_imm, req_last, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt,
    output req_rd, req_imm, req_last, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS requests and streams the words into
// instruction memory through a small FIFO.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                rst,
  instr_encoder_loader_if.slave bus,
  input  logic                restart,
  output logic [ADDR_WIDTH:0] words_written,
  output logic                err,
  output logic                done
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [31:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW:0]           count;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  legal;
  logic                  rtype;
  logic                  push;
  logic                  pop;
  logic [5:0]            funct;
  logic [5:0]            opcode;
  logic [31:0]           word;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign bus.req_ready  = (state == LOAD) && !full;
  assign bus.imem_we    = !empty;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = mem[rptr];
  assign done           = (state == DONE);

  assign accept = bus.req_valid && bus.req_ready;
  assign push   = accept && legal;
  assign pop    = bus.imem_we && bus.imem_ready;

  always_comb begin
    legal  = 1'b1;
    rtype  = 1'b0;
    funct  = 6'h00;
    opcode = 6'h00;
    unique case (1'b1)
      bus.req_op == 4'd0: begin rtype = 1'b1; funct = 6'h20; end
      bus.req_op == 4'd1: begin rtype = 1'b1; funct = 6'h22; end
      bus.req_op == 4'd2: begin rtype = 1'b1; funct = 6'h24; end
      bus.req_op == 4'd3: begin rtype = 1'b1; funct = 6'h25; end
      bus.req_op == 4'd4: begin rtype = 1'b1; funct = 6'h2A; end
      bus.req_op == 4'd5: opcode = 6'h08;
      bus.req_op == 4'd6: opcode = 6'h23;
      bus.req_op == 4'd7: opcode = 6'h2B;
      bus.req_op == 4'd8: opcode = 6'h04;
      default:            legal = 1'b0;
    endcase
    if (rtype) begin
      word = {6'h00, bus.req_rs, bus.req_rt,
              bus.req_rd, 5'b0, funct};
    end else begin
      word = {opcode, bus.req_rs, bus.req_rt, bus.req_imm};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      addr          <= ADDR_WIDTH'(BASE_ADDR);
      words_written <= '0;
      err           <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
        addr <= addr + 1'b1;
        if (words_written != '1) begin
          words_written <= words_written + 1'b1;
        end
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && !legal) begin
        err <= 1'b1;
      end
      unique case (state)
        LOAD: begin
          if (accept && bus.req_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (restart) begin
            state         <= LOAD;
            addr          <= ADDR_WIDTH'(BASE_ADDR);
            words_written <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
